// File: rtl/cola_dispense_ctrl.sv
// Vend sequencer: queues up to two vend requests and drives the dispense
// solenoid and change ejector in a fixed timed order, with LED status.
module cola_dispense_ctrl #(
  parameter int DISP_CYC = 25000000,
  parameter int CHG_CYC  = 12500000,
  parameter int GAP_CYC  = 12500000,
  parameter int CNT_W    = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [1:0] req_change,
  output logic       req_ready,
  input  logic       err_clr,
  output logic       disp_out,
  output logic       chg_out,
  output logic       busy,
  output logic       done_pulse,
  output logic       drop_err,
  output logic       chg_err,
  output logic [7:0] led
);

  localparam logic [CNT_W-1:0] DISP_LAST = CNT_W'(DISP_CYC - 1);
  localparam logic [CNT_W-1:0] CHG_LAST  = CNT_W'(CHG_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DISP = 3'd1,
    GAP  = 3'd2,
    CHG  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic [1:0]       chg_left;
  logic [1:0]       count;
  logic [1:0]       mem [2];
  logic             alive;
  logic             push;
  logic             pop;
  logic [1:0]       wdata;

  // The ejector holds at most two coins; an illegal 3 is clamped to 2.
  function automatic logic [1:0] clamp_change(input logic [1:0] c);
    return (c == 2'd3) ? 2'd2 : c;
  endfunction

  assign req_ready = alive && (count != 2'd2);
  assign push      = req_valid && req_ready;
  assign pop       = (state == IDLE) && (count != 2'd0);
  assign wdata     = clamp_change(req_change);

  // FIFO occupancy, ready gating and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= 2'd0;
      alive    <= 1'b0;
      drop_err <= 1'b0;
      chg_err  <= 1'b0;
    end else begin
      alive <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (req_valid && !req_ready) drop_err <= 1'b1;
      else if (err_clr)            drop_err <= 1'b0;
      if (push && req_change == 2'd3) chg_err <= 1'b1;
      else if (err_clr)               chg_err <= 1'b0;
    end
  end

  // Entry storage; a simultaneous push/pop at count 1 lands the new entry at the head
  always_ff @(posedge clk) begin
    if (pop) begin
      mem[0] <= (push && count == 2'd1) ? wdata : mem[1];
    end else if (push) begin
      mem[count[0]] <= wdata;
    end
  end

  // Sequencer with outputs registered from the next-state decision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      chg_left   <= 2'd0;
      disp_out   <= 1'b0;
      chg_out    <= 1'b0;
      busy       <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      disp_out   <= 1'b0;
      chg_out    <= 1'b0;
      done_pulse <= 1'b0;
      busy       <= 1'b1;
      case (state)
        IDLE: begin
          timer <= '0;
          if (pop) begin
            state    <= DISP;
            chg_left <= mem[0];
            disp_out <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        DISP: begin
          if (timer == DISP_LAST) begin
            state <= GAP;
            timer <= '0;
          end else begin
            timer    <= timer + CNT_W'(1);
            disp_out <= 1'b1;
          end
        end
        GAP: begin
          if (timer == GAP_LAST) begin
            timer <= '0;
            if (chg_left != 2'd0) begin
              state   <= CHG;
              chg_out <= 1'b1;
            end else begin
              state      <= DONE;
              done_pulse <= 1'b1;
            end
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end
        CHG: begin
          if (timer == CHG_LAST) begin
            state    <= GAP;
            timer    <= '0;
            chg_left <= chg_left - 2'd1;
          end else begin
            timer   <= timer + CNT_W'(1);
            chg_out <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          timer <= '0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          timer <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign led = {busy, disp_out, chg_out, drop_err | chg_err, count, chg_left};

endmodule

// File: tb/tb_cola_dispense_ctrl.sv
// Directed bench for cola_dispense_ctrl with short timing parameters
// (DISP=4, CHG=3, GAP=2); expected waveforms are hand-derived bit patterns.
module tb_cola_dispense_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_change = 2'd0;
  logic       err_clr = 1'b0;
  logic       req_ready, disp_out, chg_out, busy, done_pulse, drop_err, chg_err;
  logic [7:0] led;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] disp_v, chg_v, done_v, busy_v;
  logic [7:0]  led_v [64];

  cola_dispense_ctrl #(
    .DISP_CYC(4),
    .CHG_CYC (3),
    .GAP_CYC (2),
    .CNT_W   (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_change(req_change),
    .req_ready (req_ready),
    .err_clr   (err_clr),
    .disp_out  (disp_out),
    .chg_out   (chg_out),
    .busy      (busy),
    .done_pulse(done_pulse),
    .drop_err  (drop_err),
    .chg_err   (chg_err),
    .led       (led)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_v;
    disp_v = '0; chg_v = '0; done_v = '0; busy_v = '0;
    for (int j = 0; j < 64; j++) led_v[j] = 8'h00;
  endtask

  task automatic sample(input int i);
    disp_v[i] = disp_out;
    chg_v[i]  = chg_out;
    done_v[i] = done_pulse;
    busy_v[i] = busy;
    led_v[i]  = led;
  endtask

  task automatic push_req(input logic [1:0] c);
    req_valid = 1'b1; req_change = c;
    tick;
    req_valid = 1'b0; req_change = 2'd0;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #20;
    n_cmp++; if (led !== 8'h00) begin $display("FAIL reset_led: got %h want 00", led); n_bad++; end
    n_cmp++; if (req_ready !== 1'b0) begin $display("FAIL reset_ready: got %b want 0", req_ready); n_bad++; end
    n_cmp++;
    if ({disp_out, chg_out, busy, done_pulse, drop_err, chg_err} !== 6'b0) begin
      $display("FAIL reset_outs: got %b want 000000", {disp_out, chg_out, busy, done_pulse, drop_err, chg_err});
      n_bad++;
    end
    @(negedge clk) rst_n = 1'b1;
    tick;
    n_cmp++; if (req_ready !== 1'b1) begin $display("FAIL release_ready: got %b want 1", req_ready); n_bad++; end
    n_cmp++; if (led !== 8'h00) begin $display("FAIL release_led: got %h want 00", led); n_bad++; end
  endtask

  task automatic test_single;
    int mis;
    clear_v;
    push_req(2'd0);
    n_cmp++; if (led[3:2] !== 2'd1 || busy !== 1'b0) begin $display("FAIL single_queued: got cnt %0d busy %b want 1 0", led[3:2], busy); n_bad++; end
    for (int i = 1; i <= 12; i++) begin tick; sample(i); end
    n_cmp++; if (disp_v[15:0] !== 16'h001E) begin $display("FAIL single_disp: got %h want 001e", disp_v[15:0]); n_bad++; end
    n_cmp++; if (busy_v[15:0] !== 16'h00FE) begin $display("FAIL single_busy: got %h want 00fe", busy_v[15:0]); n_bad++; end
    n_cmp++; if (done_v[15:0] !== 16'h0080) begin $display("FAIL single_done: got %h want 0080", done_v[15:0]); n_bad++; end
    n_cmp++; if (chg_v[15:0] !== 16'h0000) begin $display("FAIL single_chg: got %h want 0000", chg_v[15:0]); n_bad++; end
    mis = 0;
    for (int i = 1; i <= 12; i++) if (led_v[i][6] !== disp_v[i]) mis++;
    n_cmp++; if (mis != 0) begin $display("FAIL single_led6: got %0d differing cycles want 0", mis); n_bad++; end
  endtask

  task automatic test_change2;
    clear_v;
    push_req(2'd2);
    for (int i = 1; i <= 20; i++) begin tick; sample(i); end
    n_cmp++; if (disp_v[31:0] !== 32'h0000_001E) begin $display("FAIL chg2_disp: got %h want 0000001e", disp_v[31:0]); n_bad++; end
    n_cmp++; if (chg_v[31:0] !== 32'h0000_7380) begin $display("FAIL chg2_chg: got %h want 00007380", chg_v[31:0]); n_bad++; end
    n_cmp++; if (done_v[31:0] !== 32'h0002_0000) begin $display("FAIL chg2_done: got %h want 00020000", done_v[31:0]); n_bad++; end
    n_cmp++; if (busy_v[31:0] !== 32'h0003_FFFE) begin $display("FAIL chg2_busy: got %h want 0003fffe", busy_v[31:0]); n_bad++; end
    n_cmp++;
    if ({led_v[1][1:0], led_v[9][1:0], led_v[10][1:0], led_v[14][1:0], led_v[15][1:0]} !== 10'b10_10_01_01_00) begin
      $display("FAIL chg2_left: got %b want 1010010100",
               {led_v[1][1:0], led_v[9][1:0], led_v[10][1:0], led_v[14][1:0], led_v[15][1:0]});
      n_bad++;
    end
  endtask

  task automatic test_drop;
    clear_v;
    push_req(2'd0);
    for (int i = 1; i <= 26; i++) begin
      if (i == 2 || i == 3) begin req_valid = 1'b1; req_change = 2'd0; end
      if (i == 4) begin
        n_cmp++; if (req_ready !== 1'b0) begin $display("FAIL drop_ready: got %b want 0", req_ready); n_bad++; end
        req_valid = 1'b1; req_change = 2'd3; err_clr = 1'b1;
      end
      if (i == 5) err_clr = 1'b1;
      tick; sample(i);
      req_valid = 1'b0; req_change = 2'd0; err_clr = 1'b0;
      if (i == 4) begin
        n_cmp++; if (led[3:2] !== 2'd2) begin $display("FAIL drop_count: got %0d want 2", led[3:2]); n_bad++; end
        n_cmp++; if (drop_err !== 1'b1 || led[4] !== 1'b1) begin $display("FAIL drop_flag: got %b led4 %b want 1 1", drop_err, led[4]); n_bad++; end
        n_cmp++; if (chg_err !== 1'b0) begin $display("FAIL drop_chgerr: got %b want 0", chg_err); n_bad++; end
      end
      if (i == 5) begin
        n_cmp++; if (drop_err !== 1'b0 || led[4] !== 1'b0) begin $display("FAIL drop_clear: got %b led4 %b want 0 0", drop_err, led[4]); n_bad++; end
      end
    end
    n_cmp++; if (done_v[31:0] !== 32'h0080_8080) begin $display("FAIL drop_dones: got %h want 00808080", done_v[31:0]); n_bad++; end
  endtask

  task automatic test_illegal;
    clear_v;
    push_req(2'd3);
    n_cmp++; if (chg_err !== 1'b1 || led[4] !== 1'b1) begin $display("FAIL ill_flag: got %b led4 %b want 1 1", chg_err, led[4]); n_bad++; end
    for (int i = 1; i <= 20; i++) begin tick; sample(i); end
    n_cmp++; if (led_v[1][1:0] !== 2'd2) begin $display("FAIL ill_stored: got %0d want 2", led_v[1][1:0]); n_bad++; end
    n_cmp++; if (chg_v[31:0] !== 32'h0000_7380) begin $display("FAIL ill_chg: got %h want 00007380", chg_v[31:0]); n_bad++; end
    n_cmp++; if (done_v[31:0] !== 32'h0002_0000) begin $display("FAIL ill_done: got %h want 00020000", done_v[31:0]); n_bad++; end
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    n_cmp++; if (chg_err !== 1'b0) begin $display("FAIL ill_clear: got %b want 0", chg_err); n_bad++; end
  endtask

  task automatic test_reset_mid;
    clear_v;
    push_req(2'd2);
    for (int i = 1; i <= 13; i++) begin
      if (i == 2) begin req_valid = 1'b1; req_change = 2'd0; end
      tick; sample(i);
      req_valid = 1'b0; req_change = 2'd0;
    end
    n_cmp++; if (chg_out !== 1'b1 || led[3:2] !== 2'd1) begin $display("FAIL mid_pre: got chg %b cnt %0d want 1 1", chg_out, led[3:2]); n_bad++; end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({disp_out, chg_out, busy, done_pulse} !== 4'b0 || led !== 8'h00 || req_ready !== 1'b0) begin
      $display("FAIL mid_abort: got outs %b led %h rdy %b want 0000 00 0", {disp_out, chg_out, busy, done_pulse}, led, req_ready);
      n_bad++;
    end
    #12;
    @(negedge clk) rst_n = 1'b1;
    tick;
    n_cmp++; if (req_ready !== 1'b1 || led !== 8'h00) begin $display("FAIL mid_release: got rdy %b led %h want 1 00", req_ready, led); n_bad++; end
    clear_v;
    for (int i = 1; i <= 20; i++) begin tick; sample(i); end
    n_cmp++;
    if ((disp_v | chg_v | busy_v) !== 64'h0) begin
      $display("FAIL mid_quiet: got activity %h want 0", disp_v | chg_v | busy_v);
      n_bad++;
    end
  endtask

  task automatic test_push_pop;
    clear_v;
    push_req(2'd0);
    for (int i = 1; i <= 24; i++) begin
      if (i == 2) begin req_valid = 1'b1; req_change = 2'd1; end
      if (i == 9) begin
        n_cmp++; if (busy !== 1'b0 || led[3:2] !== 2'd1) begin $display("FAIL pp_idle: got busy %b cnt %0d want 0 1", busy, led[3:2]); n_bad++; end
        req_valid = 1'b1; req_change = 2'd2;
      end
      tick; sample(i);
      req_valid = 1'b0; req_change = 2'd0;
      if (i == 9) begin
        n_cmp++;
        if (led[3:2] !== 2'd1 || led[1:0] !== 2'd1 || disp_out !== 1'b1) begin
          $display("FAIL pp_same: got cnt %0d left %0d disp %b want 1 1 1", led[3:2], led[1:0], disp_out);
          n_bad++;
        end
      end
      if (i == 22) begin
        n_cmp++;
        if (led[3:2] !== 2'd0 || led[1:0] !== 2'd2 || disp_out !== 1'b1) begin
          $display("FAIL pp_next: got cnt %0d left %0d disp %b want 0 2 1", led[3:2], led[1:0], disp_out);
          n_bad++;
        end
      end
    end
    n_cmp++; if (done_v[23:0] !== 24'h10_0080) begin $display("FAIL pp_dones: got %h want 100080", done_v[23:0]); n_bad++; end
  endtask

  initial begin
    test_reset;
    test_single;
    test_change2;
    test_drop;
    test_illegal;
    test_reset_mid;
    test_push_pop;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
